// File: rtl/wb_bridge_pkg.sv
// Shared types and helpers for the Ibex-to-Wishbone master bridge.
package wb_bridge_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } bridge_state_e;

    // Counter must be able to hold TimeoutCycles itself; keep at least one bit
    // so a disabled watchdog still elaborates cleanly.
    function automatic int tmo_cnt_width(input int cycles);
        return (cycles <= 0) ? 1 : $clog2(cycles + 1);
    endfunction

endpackage

// File: rtl/wb_bus_watchdog.sv
// Saturating bus-cycle watchdog: clears on request, counts while enabled,
// flags expiry on the last allowed cycle. TimeoutCycles=0 disables it.
module wb_bus_watchdog
    import wb_bridge_pkg::*;
#(
    parameter int TimeoutCycles = 256
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expire
);

    localparam int CntW = tmo_cnt_width(TimeoutCycles);

    logic [CntW-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && cnt != {CntW{1'b1}}) begin
            cnt <= cnt + CntW'(1);
        end
    end

    assign expire = (TimeoutCycles > 0) && en && (cnt == CntW'(TimeoutCycles - 1));

endmodule

// File: rtl/ibex_wb_master_bridge.sv
// Ibex req/gnt/rvalid host port to a single pipelined Wishbone B4 master,
// one outstanding transaction, with a watchdog that turns a hung slave into an error.
module ibex_wb_master_bridge
    import wb_bridge_pkg::*;
#(
    parameter int DataWidth     = 32,
    parameter int AddressWidth  = 32,
    parameter int TimeoutCycles = 256
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    data_req_i,
    output logic                    data_gnt_o,
    input  logic                    data_we_i,
    input  logic [DataWidth/8-1:0]  data_be_i,
    input  logic [AddressWidth-1:0] data_addr_i,
    input  logic [DataWidth-1:0]    data_wdata_i,
    output logic                    data_rvalid_o,
    output logic [DataWidth-1:0]    data_rdata_o,
    output logic                    data_err_o,
    output logic                    mcyc_o,
    output logic                    mstb_o,
    output logic                    mwe_o,
    output logic [AddressWidth-1:0] maddr_o,
    output logic [DataWidth-1:0]    mdata_o,
    output logic [DataWidth/8-1:0]  msel_o,
    input  logic                    mstall_i,
    input  logic                    mack_i,
    input  logic [DataWidth-1:0]    mdata_i,
    input  logic                    merr_i
);

    localparam int BeW = DataWidth / 8;

    bridge_state_e             state;
    logic                      cyc_q, stb_q, we_q;
    logic [BeW-1:0]            be_q;
    logic [AddressWidth-1:0]   addr_q;
    logic [DataWidth-1:0]      wdata_q;
    logic                      rvalid_q, err_q;
    logic [DataWidth-1:0]      rdata_q;
    logic                      take, busy, done, expire, tmo;

    assign take = (state == IDLE) && data_req_i;
    assign busy = (state != IDLE);
    // Responses only count once the strobe has been accepted.
    assign done = ((state == REQ && !mstall_i) || state == WAIT) && (mack_i || merr_i);
    assign tmo  = expire && !done;

    wb_bus_watchdog #(
        .TimeoutCycles(TimeoutCycles)
    ) u_watchdog (
        .clk   (clk_i),
        .rst   (rst_i),
        .clr   (take),
        .en    (busy),
        .expire(expire)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state    <= IDLE;
            cyc_q    <= 1'b0;
            stb_q    <= 1'b0;
            we_q     <= 1'b0;
            be_q     <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rvalid_q <= 1'b0;
            err_q    <= 1'b0;
            rdata_q  <= '0;
        end else begin
            rvalid_q <= 1'b0;
            err_q    <= 1'b0;
            rdata_q  <= '0;
            if (state == IDLE) begin
                if (data_req_i) begin
                    state   <= REQ;
                    cyc_q   <= 1'b1;
                    stb_q   <= 1'b1;
                    we_q    <= data_we_i;
                    be_q    <= data_be_i;
                    addr_q  <= data_addr_i;
                    wdata_q <= data_wdata_i;
                end
            end else if (done || tmo) begin
                // Error (slave or watchdog) wins over ack and forces rdata to 0.
                state    <= IDLE;
                cyc_q    <= 1'b0;
                stb_q    <= 1'b0;
                rvalid_q <= 1'b1;
                err_q    <= tmo || merr_i;
                rdata_q  <= (tmo || merr_i || we_q) ? '0 : mdata_i;
            end else if (state == REQ && !mstall_i) begin
                state <= WAIT;
                stb_q <= 1'b0;
            end
        end
    end

    assign data_gnt_o    = take && !rst_i;
    assign data_rvalid_o = rvalid_q;
    assign data_err_o    = err_q;
    assign data_rdata_o  = rdata_q;
    assign mcyc_o        = cyc_q;
    assign mstb_o        = stb_q;
    assign mwe_o         = we_q;
    assign maddr_o       = addr_q;
    assign mdata_o       = wdata_q;
    assign msel_o        = be_q;

endmodule
